uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo_if.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   state_t       transmitter FSM states
//   PAR_*         parity_mode encodings
//   BAUD_DIV_DEF  default clk cycles per bit (50 MHz / 38400)
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_ODD   = 2'b10;
   localparam logic [1:0] PAR_NONE3 = 2'b11;

   localparam int unsigned BAUD_DIV_DEF = 1302;

   function automatic logic has_parity(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side handshake into the transmit FIFO.
//   tx_valid  producer offers tx_data
//   tx_ready  FIFO not full; word accepted when tx_valid && tx_ready
//   tx_data   word to transmit (LSB first on the line)
// master = producer, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with extra-bit pointers.
//   clk, rst   clock, asynchronous active-low reset
//   wr_valid   write request; taken only while wr_ready
//   wr_ready   registered not-full flag (0 during reset)
//   wr_data    write word
//   rd_en      pop request; ignored while empty
//   rd_data    word at the head of the FIFO
//   empty      FIFO holds no words
//   level      number of words held
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic             push, pop, full_nxt;

   assign push    = wr_valid && wr_ready;
   assign pop     = rd_en && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign level   = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_comb begin
      wr_nxt   = push ? wr_ptr + 1'b1 : wr_ptr;
      rd_nxt   = pop  ? rd_ptr + 1'b1 : rd_ptr;
      // Same low bits with differing wrap bit means the FIFO is full.
      full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         wr_ready <= 1'b0;
      end else begin
         wr_ptr   <= wr_nxt;
         rd_ptr   <= rd_nxt;
         wr_ready <= !full_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter (start, DATA_W bits LSB first,
// optional parity, 1 or 2 stop bits).
//   clk          clock
//   rst          asynchronous active-low reset
//   bus          producer handshake (tx_valid / tx_ready / tx_data)
//   parity_mode  00 none, 01 even, 10 odd, 11 none; latched per frame
//   stop2        0: one stop bit, 1: two stop bits; latched per frame
//   tx           registered serial line, idle high
//   busy         frame on the line or words buffered
//   fifo_level   number of buffered words
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_fifo_if.slave               bus,
   input  logic [1:0]                  parity_mode,
   input  logic                        stop2,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int unsigned BW = $clog2(BAUD_DIV);
   localparam int unsigned CW = $clog2(DATA_W);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

   state_t            state, nxt;
   logic [BW-1:0]     baud_cnt;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg, fifo_dout;
   logic              par_bit, use_par, two_stop;
   logic              pop, fifo_empty, bit_end, line;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (bus.tx_valid),
      .wr_ready (bus.tx_ready),
      .wr_data  (bus.tx_data),
      .rd_en    (pop),
      .rd_data  (fifo_dout),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_comb begin
      nxt  = state;
      pop  = 1'b0;
      line = 1'b1;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               nxt = START;
            end
         end
         START: begin
            line = 1'b0;
            if (bit_end) nxt = DATA;
         end
         DATA: begin
            line = shreg[0];
            if (bit_end && bit_cnt == BIT_LAST) nxt = use_par ? PARITY : STOP;
         end
         PARITY: begin
            line = par_bit;
            if (bit_end) nxt = STOP;
         end
         STOP: begin
            // Chain straight into the next start bit when more words wait.
            if (bit_end && (!two_stop || bit_cnt == CW'(1))) begin
               if (!fifo_empty) begin
                  pop = 1'b1;
                  nxt = START;
               end else begin
                  nxt = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // tx registers the line value of the current state, so the line trails
   // the FSM by one cycle: accept edge -> pop edge -> tx falls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         use_par  <= 1'b0;
         two_stop <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state <= nxt;
         tx    <= line;
         busy  <= (state != IDLE) || !fifo_empty;

         if (state == IDLE || bit_end) baud_cnt <= '0;
         else                          baud_cnt <= baud_cnt + 1'b1;

         if (nxt != state) bit_cnt <= '0;
         else if (bit_end) bit_cnt <= bit_cnt + 1'b1;

         if (pop) begin
            shreg    <= fifo_dout;
            par_bit  <= (^fifo_dout) ^ (parity_mode == PAR_ODD);
            use_par  <= has_parity(parity_mode);
            two_stop <= stop2;
         end else if (state == DATA && bit_end) begin
            shreg <= shreg >> 1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo (DATA_W=8, BAUD_DIV=4,
// FIFO_DEPTH=4). Pushes record expected frames; a line monitor pops and
// checks every bit at mid-bit.
module tb_uart_tx_fifo;

   localparam int unsigned BD = 4;

   typedef struct {
      logic [7:0] data;
      logic [1:0] pm;
      logic       s2;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       tx, busy;
   logic [2:0] fifo_level;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned n_frames = 0;
   logic        mon_en   = 1'b1;
   logic        mon_busy = 1'b0;

   exp_t        exp_q[$];
   int unsigned start_t[$];

   uart_tx_fifo_if #(.DATA_W(8)) bus ();

   uart_tx_fifo #(
      .DATA_W     (8),
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx          (tx),
      .busy        (busy),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [1:0] pm_e, input logic s2_e,
                       input logic acc);
      exp_t it;
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      check($sformatf("tx_ready_push_%02h", d), 32'(bus.tx_ready), 32'(acc));
      if (acc) begin
         it.data = d;
         it.pm   = pm_e;
         it.s2   = s2_e;
         exp_q.push_back(it);
      end
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned k = 0;
      logic        ok;
      do begin
         @(negedge clk);
         k++;
         ok = (exp_q.size() == 0) && (busy === 1'b0) && !mon_busy;
      end while (!ok && k < budget);
      check("idle_reached", 32'(ok), 32'd1);
      check("idle_level", 32'(fifo_level), 32'd0);
   endtask

   task automatic wait_tx_low(input int unsigned budget);
      int unsigned k = 0;
      while (tx !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("tx_low_seen", 32'(tx), 32'd0);
   endtask

   // Line monitor: detect start bit, check each bit 1.5 cycles into it.
   initial begin : monitor
      exp_t        it;
      logic [11:0] bits;
      int unsigned nb;
      forever begin
         @(negedge clk);
         if (mon_en && rst === 1'b1 && tx === 1'b0) begin
            start_t.push_back(cyc);
            mon_busy = 1'b1;
            if (exp_q.size() == 0) begin
               check("frame_unexpected", 32'd1, 32'd0);
               repeat (12 * BD) @(negedge clk);
            end else begin
               it = exp_q.pop_front();
               bits = '0;
               bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) bits[i+1] = it.data[i];
               nb = 9;
               if (it.pm == 2'b01 || it.pm == 2'b10) begin
                  bits[nb] = (^it.data) ^ (it.pm == 2'b10);
                  nb++;
               end
               bits[nb] = 1'b1;
               nb++;
               if (it.s2) begin
                  bits[nb] = 1'b1;
                  nb++;
               end
               @(negedge clk);
               for (int i = 0; i < int'(nb); i++) begin
                  if (i > 0) repeat (BD) @(negedge clk);
                  check($sformatf("frame%0d_%02h_bit%0d", n_frames, it.data, i),
                        32'(tx), 32'(bits[i]));
               end
               repeat (2) @(negedge clk);
               check($sformatf("frame%0d_stop_hold", n_frames), 32'(tx), 32'd1);
               n_frames++;
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int unsigned cnt;
      rst          = 1'b0;
      parity_mode  = 2'b00;
      stop2        = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(bus.tx_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      rst = 1'b1;
      #1;
      check("ready_before_edge", 32'(bus.tx_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(bus.tx_ready), 32'd1);

      // Plain frame and accept-to-start latency
      push(8'hA5, 2'b00, 1'b0, 1'b1);
      @(negedge clk);
      check("lat_n0", 32'(tx), 32'd1);
      @(negedge clk);
      check("lat_n1", 32'(tx), 32'd1);
      @(negedge clk);
      check("lat_n2", 32'(tx), 32'd0);
      wait_idle(100);

      // Even then odd parity
      parity_mode = 2'b01;
      push(8'hA5, 2'b01, 1'b0, 1'b1);
      wait_idle(100);
      parity_mode = 2'b10;
      push(8'hA5, 2'b10, 1'b0, 1'b1);
      wait_idle(100);

      // Two stop bits, back-to-back frames, busy duration
      parity_mode = 2'b00;
      stop2 = 1'b1;
      start_t.delete();
      push(8'h01, 2'b00, 1'b1, 1'b1);
      push(8'h80, 2'b00, 1'b1, 1'b1);
      wait_tx_low(20);
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", cnt, 32'd88);
      wait_idle(100);
      check("start_count", start_t.size(), 32'd2);
      if (start_t.size() == 2) check("start_gap", start_t[1] - start_t[0], 32'd44);
      stop2 = 1'b0;

      // Overfill: fifth word fills the FIFO, sixth is dropped
      push(8'h11, 2'b00, 1'b0, 1'b1);
      push(8'h22, 2'b00, 1'b0, 1'b1);
      push(8'h33, 2'b00, 1'b0, 1'b1);
      push(8'h44, 2'b00, 1'b0, 1'b1);
      push(8'h55, 2'b00, 1'b0, 1'b1);
      push(8'h5A, 2'b00, 1'b0, 1'b0);
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_ready", 32'(bus.tx_ready), 32'd0);
      wait_idle(400);

      // Parity change mid-frame applies only to the next frame
      push(8'h3C, 2'b00, 1'b0, 1'b1);
      wait_tx_low(20);
      repeat (10) @(negedge clk);
      push(8'hC3, 2'b10, 1'b0, 1'b1);
      parity_mode = 2'b10;
      wait_idle(200);
      parity_mode = 2'b00;

      // Reset in the middle of data bit 3
      mon_en = 1'b0;
      push(8'h96, 2'b00, 1'b0, 1'b1);
      push(8'h11, 2'b00, 1'b0, 1'b1);
      push(8'h22, 2'b00, 1'b0, 1'b1);
      exp_q.delete();
      wait_tx_low(20);
      repeat (18) @(negedge clk);
      check("pre_rst_bit3", 32'(tx), 32'd0);
      check("pre_rst_level", 32'(fifo_level), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_tx", 32'(tx), 32'd1);
      check("async_rst_level", 32'(fifo_level), 32'd0);
      check("async_rst_ready", 32'(bus.tx_ready), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_tx_idle", 32'(tx), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      mon_en = 1'b1;
      push(8'h96, 2'b00, 1'b0, 1'b1);
      wait_idle(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
